phy_tx_par2ser: RTL

Parallel-to-serial stage of the transmit PHY, directly downstream of the 4:1 byte mux tree. It accepts the mux tree's byte/valid stream through a small buffer and emits one bit per clock, MSB first. It fills every slot without a valid byte with the COM character (0xBC). After reset it sends a mandatory run of COM symbols so the receiver can align before any data.

---
 rtl/phy_tx_par2ser_pkg.sv | 15 +
 rtl/phy_tx_par2ser_if.sv | 23 ++
 rtl/phy_tx_fifo.sv | 71 +++++++
 rtl/phy_tx_par2ser.sv | 115 +++++++++++
 4 files changed

// File: rtl/phy_tx_par2ser_pkg.sv
// phy_tx_par2ser_pkg: shared symbol constants and state type for the
// transmit PHY serializer and the receive-side aligner.
package phy_tx_par2ser_pkg;

  localparam int          SYM_W          = 8;
  localparam logic [7:0]  COM_CHAR_DEF   = 8'hBC;
  localparam int          SYNC_COUNT_DEF = 4;
  localparam int          FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/phy_tx_par2ser_if.sv
// phy_tx_par2ser_if: byte/valid/ready stream from the 4:1 mux tree
// into the serializer.
interface phy_tx_par2ser_if
  import phy_tx_par2ser_pkg::*;
();

  logic [SYM_W-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );

endinterface

// File: rtl/phy_tx_fifo.sv
// phy_tx_fifo: small synchronous FIFO buffering mux-tree bytes ahead of
// the serializer; head is presented combinationally on dout.
module phy_tx_fifo
  import phy_tx_par2ser_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [SYM_W-1:0] din,
  output logic [SYM_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [SYM_W-1:0] mem_q [DEPTH];
  logic [SYM_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/phy_tx_par2ser.sv
// phy_tx_par2ser: buffers mux-tree bytes and shifts them out MSB first,
// one bit per clk_32f, filling idle slots and the post-reset run with COM.
module phy_tx_par2ser
  import phy_tx_par2ser_pkg::*;
#(
  parameter logic [SYM_W-1:0] COM_CHAR   = COM_CHAR_DEF,
  parameter int               SYNC_COUNT = SYNC_COUNT_DEF,
  parameter int               FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk_32f,
  input  logic              reset,
  phy_tx_par2ser_if.slave   in_if,
  output logic              data_out,
  output logic              sym_start,
  output logic              is_data,
  output logic              active,
  output logic              com_alias
);

  localparam int SCW = $clog2(SYNC_COUNT + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [SYM_W-1:0] shreg_q, shreg_d;
  logic             sym_is_data_q, sym_is_data_d;
  tx_state_e        state_q, state_d;
  logic [SCW-1:0]   sync_cnt_q, sync_cnt_d;
  logic             com_alias_q, com_alias_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic [SYM_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  assign in_if.ready_out = (fifo_count < CW'(FIFO_DEPTH));
  assign fifo_push = in_if.valid_in & in_if.ready_out & ~fifo_full;

  phy_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_32f),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_if.data_in),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign data_out  = shreg_q[SYM_W-1];
  assign sym_start = (bit_cnt_q == 3'd0);
  assign is_data   = sym_is_data_q;
  assign active    = (state_q == ST_ACTIVE);
  assign com_alias = com_alias_q;

  always_comb begin
    bit_cnt_d     = bit_cnt_q + 3'd1;
    shreg_d       = {shreg_q[SYM_W-2:0], 1'b0};
    sym_is_data_d = sym_is_data_q;
    state_d       = state_q;
    sync_cnt_d    = sync_cnt_q;
    com_alias_d   = 1'b0;
    fifo_pop      = 1'b0;
    if (bit_cnt_q == 3'd7) begin
      bit_cnt_d = 3'd0;
      unique case (state_q)
        ST_SYNC: begin
          shreg_d       = COM_CHAR;
          sym_is_data_d = 1'b0;
          sync_cnt_d    = sync_cnt_q + SCW'(1);
          if (sync_cnt_d == SCW'(SYNC_COUNT)) begin
            state_d = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // Data equal to COM goes out unchanged; the flag lets the
          // link layer tell it apart from a filler symbol.
          if (!fifo_empty) begin
            fifo_pop      = 1'b1;
            shreg_d       = fifo_head;
            sym_is_data_d = 1'b1;
            com_alias_d   = (fifo_head == COM_CHAR);
          end else begin
            shreg_d       = COM_CHAR;
            sym_is_data_d = 1'b0;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt_q     <= 3'd7;
      shreg_q       <= '0;
      sym_is_data_q <= 1'b0;
      state_q       <= ST_SYNC;
      sync_cnt_q    <= '0;
      com_alias_q   <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      sym_is_data_q <= sym_is_data_d;
      state_q       <= state_d;
      sync_cnt_q    <= sync_cnt_d;
      com_alias_q   <= com_alias_d;
    end
  end

endmodule
